// File: rtl/ts_packet_fifo.sv
// ts_packet_fifo: store-and-forward FIFO for fixed-length TS packets.
// Words become readable only after their whole packet has been committed.
module ts_packet_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int PKT_LEN = 188,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD = 8'h47
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [ADDR_WIDTH:0]   pkt_count,
  output logic                  drop_pulse
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(PKT_LEN + 1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_PKT,
    W_DROP
  } wst_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_wr_commit;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_pkt_cnt;
  logic [CW-1:0]         r_wcnt;
  logic [CW-1:0]         r_rcnt;
  wst_t                  r_wst;
  logic                  r_drop;
  logic                  r_ov;
  logic [DATA_WIDTH-1:0] r_odata;

  logic          w_start;
  logic          w_good;
  logic [PW-1:0] w_base;
  logic [PW-1:0] w_occ;
  logic          w_full;
  logic [CW-1:0] w_idx;
  logic          w_last;
  logic          w_pkt_word;
  logic          w_we;
  logic          w_commit;
  logic          w_xfer;
  logic          w_eop_x;
  logic [PW-1:0] w_fetch;
  logic          w_avail;
  logic          w_load;

  // A sop always restarts at the commit point, discarding any partial packet.
  assign w_start    = in_valid & in_sop;
  assign w_good     = w_start & (in_data == SYNC_WORD);
  assign w_base     = w_start ? r_wr_commit : r_wr_ptr;
  // rd_ptr is the head word not yet transferred, so it still occupies a slot.
  assign w_occ      = w_base - r_rd_ptr;
  assign w_full     = (w_occ == PW'(DEPTH));
  assign w_idx      = w_start ? '0 : r_wcnt;
  assign w_last     = (w_idx == CW'(PKT_LEN - 1));
  assign w_pkt_word = in_valid & (r_wst == W_PKT);
  assign w_we       = !w_full & (w_start ? w_good : w_pkt_word);
  assign w_commit   = w_we & w_last;

  assign w_xfer  = r_ov & out_ready;
  assign w_eop_x = w_xfer & (r_rcnt == CW'(PKT_LEN - 1));
  assign w_fetch = r_rd_ptr + PW'(w_xfer);
  assign w_avail = (w_fetch != r_wr_commit);
  assign w_load  = !r_ov | w_xfer;

  // Packet storage; only uncommitted slots are ever written.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_base[ADDR_WIDTH-1:0]] <= in_data;
    end
  end

  // Write FSM: speculative write pointer, commit on the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wst       <= W_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_wcnt      <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_we) begin
        r_drop   <= w_start & (r_wst == W_PKT);
        r_wr_ptr <= w_base + 1'b1;
        if (w_last) begin
          r_wr_commit <= w_base + 1'b1;
          r_wcnt      <= '0;
          r_wst       <= W_IDLE;
        end else begin
          r_wcnt <= w_idx + 1'b1;
          r_wst  <= W_PKT;
        end
      end else if (w_start | w_pkt_word) begin
        r_drop   <= 1'b1;
        r_wr_ptr <= r_wr_commit;
        r_wcnt   <= '0;
        r_wst    <= W_DROP;
      end
    end
  end

  // Registered FWFT head, read position and committed packet count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_ov      <= 1'b0;
      r_odata   <= '0;
      r_rcnt    <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_rd_ptr  <= w_fetch;
      r_pkt_cnt <= r_pkt_cnt + PW'(w_commit) - PW'(w_eop_x);
      if (w_xfer) begin
        r_rcnt <= w_eop_x ? '0 : r_rcnt + 1'b1;
      end
      if (w_load) begin
        r_ov <= w_avail;
        if (w_avail) begin
          r_odata <= r_mem[w_fetch[ADDR_WIDTH-1:0]];
        end
      end
    end
  end

  assign out_data   = r_odata;
  assign out_valid  = r_ov;
  assign out_sop    = r_ov & (r_rcnt == '0);
  assign out_eop    = r_ov & (r_rcnt == CW'(PKT_LEN - 1));
  assign pkt_count  = r_pkt_cnt;
  assign drop_pulse = r_drop;

endmodule

// File: tb/tb_ts_packet_fifo.sv
// tb_ts_packet_fifo: randomized bench for ts_packet_fifo.
// Reference keeps packets as word queues and counts stored words.
module tb_ts_packet_fifo;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int PL = 188;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_sop;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;
  logic [AW:0]   pkt_count;
  logic          drop_pulse;

  always #5 clk = ~clk;

  ts_packet_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .PKT_LEN(PL),
    .SYNC_WORD(8'h47)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_sop(in_sop),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .pkt_count(pkt_count),
    .drop_pulse(drop_pulse)
  );

  int n_tests = 0;
  int n_fail = 0;

  // committed words not yet transferred: {sop, eop, data}
  logic [9:0] q_out[$];
  logic [7:0] part[$];
  int mst = 0;
  int lat_wait = 0;
  int n_xfer = 0;
  int n_drop = 0;
  int n_valid = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_pkts();
    int c = 0;
    foreach (q_out[i]) if (q_out[i][8]) c++;
    return c;
  endfunction

  function automatic logic rdy(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic step(input logic v, input logic s,
                      input logic [7:0] d, input logic r);
    logic xf;
    logic drop;
    in_valid = v;
    in_sop = s;
    in_data = d;
    out_ready = r;
    xf = out_valid & r;
    if (out_valid) n_valid++;
    if (q_out.size() == 0) begin
      chk("valid_idle", 32'(out_valid), 32'(0));
      lat_wait = 0;
    end else if (out_valid) begin
      chk("head", 32'({out_sop, out_eop, out_data}), 32'(q_out[0]));
      lat_wait = 0;
    end else begin
      lat_wait++;
      chk("fwft_lat", 32'(lat_wait <= 2), 32'(1));
    end
    if (!out_valid) chk("flags_idle", 32'({out_sop, out_eop}), 32'(0));
    @(posedge clk);
    #1;
    drop = 1'b0;
    if (v && s) begin
      if (mst == 1) drop = 1'b1;
      part.delete();
      if (d == 8'h47 && q_out.size() < DEPTH) begin
        part.push_back(d);
        mst = 1;
      end else begin
        drop = 1'b1;
        mst = 2;
      end
    end else if (v && mst == 1) begin
      if (q_out.size() + part.size() >= DEPTH) begin
        part.delete();
        drop = 1'b1;
        mst = 2;
      end else begin
        part.push_back(d);
      end
    end
    if (part.size() == PL) begin
      foreach (part[i]) q_out.push_back({i == 0, i == PL - 1, part[i]});
      part.delete();
      mst = 0;
    end
    if (xf) begin
      n_xfer++;
      if (q_out.size() > 0) void'(q_out.pop_front());
    end
    if (drop_pulse) n_drop++;
    chk("drop_pulse", 32'(drop_pulse), 32'(drop));
    chk("pkt_count", 32'(pkt_count), 32'(model_pkts()));
  endtask

  task automatic send_pkt(input logic [7:0] first, input int n,
                          input int rmode, input bit rnd);
    for (int i = 0; i < n; i++) begin
      step(1'b1, i == 0,
           (i == 0) ? first : (rnd ? 8'($urandom) : 8'(i)), rdy(rmode));
    end
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rdy(rmode));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_sop", 32'(out_sop), 32'(0));
    chk("rst_eop", 32'(out_eop), 32'(0));
    chk("rst_drop", 32'(drop_pulse), 32'(0));
    chk("rst_data", 32'(out_data), 32'(0));
    chk("rst_pkt_count", 32'(pkt_count), 32'(0));
    q_out.delete();
    part.delete();
    mst = 0;
    lat_wait = 0;
    in_valid = 1'b0;
    in_sop = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    do_reset();

    n_xfer = 0;
    n_drop = 0;
    send_pkt(8'h47, PL, 1, 1'b0);
    idle(200, 1);
    chk("good_words", 32'(n_xfer), 32'(PL));
    chk("good_drops", 32'(n_drop), 32'(0));

    n_drop = 0;
    n_valid = 0;
    send_pkt(8'h46, PL, 1, 1'b1);
    idle(5, 1);
    chk("bad_drops", 32'(n_drop), 32'(1));
    chk("bad_valid", 32'(n_valid), 32'(0));
    chk("bad_pkt_count", 32'(pkt_count), 32'(0));

    n_drop = 0;
    n_xfer = 0;
    repeat (3) send_pkt(8'h47, PL, 0, 1'b1);
    chk("ovf_pkt_count", 32'(pkt_count), 32'(2));
    chk("ovf_drops", 32'(n_drop), 32'(1));
    idle(400, 1);
    chk("ovf_words", 32'(n_xfer), 32'(2 * PL));

    n_drop = 0;
    n_xfer = 0;
    send_pkt(8'h47, 101, 1, 1'b1);
    send_pkt(8'h47, PL, 1, 1'b1);
    idle(200, 1);
    chk("trunc_drops", 32'(n_drop), 32'(1));
    chk("trunc_words", 32'(n_xfer), 32'(PL));

    repeat (10) send_pkt(8'h47, PL, 2, 1'b1);
    for (int p = 0; p < 20; p++) begin
      send_pkt(($urandom_range(0, 7) == 0) ? 8'h46 : 8'h47,
               ($urandom_range(0, 5) == 0) ? $urandom_range(1, PL - 1) : PL,
               2, 1'b1);
      idle($urandom_range(0, 3), 2);
    end
    idle(700, 1);
    chk("rand_drained", 32'(q_out.size()), 32'(0));
    chk("rand_pkt_count", 32'(pkt_count), 32'(0));

    send_pkt(8'h47, PL, 1, 1'b1);
    send_pkt(8'h47, 50, 1, 1'b1);
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    do_reset();
    n_xfer = 0;
    n_drop = 0;
    send_pkt(8'h47, PL, 1, 1'b1);
    idle(200, 1);
    chk("post_rst_words", 32'(n_xfer), 32'(PL));
    chk("post_rst_drops", 32'(n_drop), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_packet_fifo.md
TS_PACKET_FIFO -- requirements
Module: ts_packet_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, which sets the byte/word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 9, which sets DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter PKT_LEN, default 188, which sets the words per TS packet; DEPTH >= PKT_LEN.
REQ-004 The block SHALL have parameter SYNC_WORD, default 8'h47, which sets the required first word of a packet.
REQ-005 The block SHALL have port clk, input, width 1, the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port rst_n, input, width 1, the reset; it is asynchronous and active-low.
REQ-007 The block SHALL have port in_data, input, width DATA_WIDTH, the stream word.
REQ-008 The block SHALL have port in_valid, input, width 1, which qualifies in_data; there is no input backpressure.
REQ-009 The block SHALL have port in_sop, input, width 1, which marks the first word of a packet.
REQ-010 The block SHALL have port out_data, output, width DATA_WIDTH, the head word in first-word-fall-through order.
REQ-011 The block SHALL have port out_valid, output, width 1, which means out_data holds a word of a committed packet.
REQ-012 The block SHALL have port out_ready, input, width 1, the downstream accept; a transfer occurs when out_valid && out_ready.
REQ-013 The block SHALL have ports out_sop and out_eop, output, width 1 each, which mark word 0 and word PKT_LEN-1 of the output packet.
REQ-014 The block SHALL have port pkt_count, output, width ADDR_WIDTH+1, the number of committed packets held.
REQ-015 The block SHALL have port drop_pulse, output, width 1, a one-cycle pulse per discarded packet.

Function
REQ-016 The write FSM SHALL have states W_IDLE, W_PKT and W_DROP.
REQ-017 In W_IDLE, in_valid && in_sop && in_data==SYNC_WORD SHALL write word 0, set wcnt=1 and go to W_PKT.
REQ-018 In W_IDLE, in_valid && in_sop with a bad sync word SHALL pulse drop_pulse and go to W_DROP.
REQ-019 In W_IDLE, valid words with in_sop=0 SHALL be ignored without a drop pulse.
REQ-020 In W_PKT, each in_valid word SHALL be written at the speculative pointer wr_ptr, and wcnt SHALL increment.
REQ-021 When word PKT_LEN-1 is written, the block SHALL set wr_commit <= wr_ptr+1, increment pkt_count, and go to W_IDLE in the same edge.
REQ-022 In W_PKT, a write when occupancy (wr_ptr - rd_ptr, ADDR_WIDTH+1-bit pointers, modulo arithmetic) == DEPTH SHALL be an overflow.
- The block SHALL rewind wr_ptr to wr_commit, pulse drop_pulse and go to W_DROP; the word is discarded.
REQ-023 In W_PKT, in_valid && in_sop with wcnt != 0 SHALL be a truncated packet.
- The block SHALL rewind wr_ptr to wr_commit and pulse drop_pulse.
- The new word SHALL then be handled per REQ-017/018 in the same cycle.
REQ-024 In W_DROP, words SHALL be ignored until in_valid && in_sop, which is evaluated per REQ-017/018 in the same cycle.
REQ-025 The read side SHALL only read words below wr_commit; uncommitted words are never visible.
REQ-026 The output stage SHALL be a registered FWFT head.
- out_valid SHALL assert no later than 2 cycles after the commit edge when the block was empty.
- out_valid SHALL hold, with out_data stable, until the transfer.
REQ-027 The read counter rcnt (0..PKT_LEN-1) SHALL drive out_sop=(rcnt==0) and out_eop=(rcnt==PKT_LEN-1), both qualified by out_valid; rcnt wraps to 0 after eop.
REQ-028 Back-to-back packets SHALL stream at one word per cycle while out_ready=1.
REQ-029 An eop transfer SHALL decrement pkt_count.
- A simultaneous commit and eop transfer SHALL leave pkt_count unchanged.
REQ-030 Freed space SHALL be usable by the write side from the cycle after the transfer.
REQ-031 Pointer wrap-around SHALL be transparent, and a packet may straddle address DEPTH-1 -> 0.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously clear wr_ptr, wr_commit, rd_ptr, wcnt, rcnt and pkt_count, and set the FSM to W_IDLE.
REQ-033 While rst_n=0, out_valid, out_sop, out_eop and drop_pulse SHALL be 0, and out_data SHALL be 0.
REQ-034 Reset SHALL discard all stored and partial packets.
- After release, the first accepted word SHALL be a valid sop.

Verification
REQ-035 A directed test SHALL cover a good packet: one 188-word packet 0x47,1..187 with out_ready=1 -> out_valid within 2 cycles of commit; 188 words in order; out_sop on 0x47, out_eop on 187; pkt_count 1->0.
REQ-036 A directed test SHALL cover a bad sync word: sop word 0x46 plus 187 words -> drop_pulse=1 for one cycle, out_valid never asserts, pkt_count=0.
REQ-037 A directed test SHALL cover overflow: ADDR_WIDTH=9, out_ready=0, three packets sent -> packets 1-2 commit (pkt_count=2); packet 3 overflows at word 136 -> drop_pulse; drain yields exactly 376 words.
REQ-038 A directed test SHALL cover truncation: sop, 100 words, then a new valid sop packet -> one drop_pulse; only the second packet appears at output.
REQ-039 A directed test SHALL cover simultaneous commit/eop plus wrap: continuous input with random out_ready over 10 packets -> pkt_count never mismatches the reference model, data intact across pointer wrap.
REQ-040 A directed test SHALL cover reset mid-packet: rst_n low at word 50 of packet 2 while packet 1 drains -> all outputs 0 immediately; after release the next good packet is output alone.
